// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with a latency-matched pixel pipeline.
// Optional internal colour-bar source is enabled by defining VGA_TESTPATTERN_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int H_SYNC_POL    = 0,
  parameter int V_SYNC_POL    = 0,
  parameter int SCALE_LOG2    = 0,
  parameter int FETCH_LATENCY = 1,
  parameter int CBITS         = 4
) (
  input  logic               clk_25_175,
  input  logic               reset,
`ifdef VGA_TESTPATTERN_EN
  input  logic               test_pattern,
`endif
  output logic [10:0]        pix_x,
  output logic [10:0]        pix_y,
  output logic               fetch_valid,
  output logic               line_start,
  output logic               frame_start,
  output logic [15:0]        frame_count,
  input  logic [3*CBITS-1:0] pixstream,
  output logic               h_sync,
  output logic               v_sync,
  output logic               drawing_pixels,
  output logic [CBITS-1:0]   r,
  output logic [CBITS-1:0]   g,
  output logic [CBITS-1:0]   b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic HPOL = (H_SYNC_POL != 0);
  localparam logic VPOL = (V_SYNC_POL != 0);

  // Pipeline word: {tp flag, pattern colour, de, vsync, hsync} with raw (active-high) flags.
`ifdef VGA_TESTPATTERN_EN
  localparam int PW = 4 + 3 * CBITS;
  localparam int BAR_SHIFT = $clog2(H_ACTIVE) - 3;
`else
  localparam int PW = 3;
`endif

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic [15:0] frame_count_q, frame_count_d;

  always_comb begin
    h_cnt_d       = h_cnt_q + 11'd1;
    v_cnt_d       = v_cnt_q;
    frame_count_d = frame_count_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d       = '0;
        frame_count_d = frame_count_q + 16'd1;
      end else begin
        v_cnt_d = v_cnt_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk_25_175) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_count_q <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_count_q <= frame_count_d;
    end
  end

  logic hs_raw, vs_raw;
  assign hs_raw      = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
  assign vs_raw      = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
  assign fetch_valid = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign line_start  = (h_cnt_q == '0);
  assign frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign pix_x       = h_cnt_q >> SCALE_LOG2;
  assign pix_y       = v_cnt_q >> SCALE_LOG2;
  assign frame_count = frame_count_q;

  logic [PW-1:0] stage0, tail;

`ifdef VGA_TESTPATTERN_EN
  logic [2:0]         bar;
  logic [3*CBITS-1:0] pattern;
  assign bar     = 3'(h_cnt_q >> BAR_SHIFT);
  assign pattern = {{CBITS{bar[2]}}, {CBITS{bar[1]}}, {CBITS{bar[0]}}};
  assign stage0  = {test_pattern, (test_pattern ? pattern : '0), fetch_valid, vs_raw, hs_raw};
`else
  assign stage0  = {fetch_valid, vs_raw, hs_raw};
`endif

  // Delay line clears to all-zero, i.e. every raw control inactive.
  generate
    if (FETCH_LATENCY == 0) begin : g_no_delay
      assign tail = stage0;
    end else begin : g_delay
      for (genvar gi = 0; gi < FETCH_LATENCY; gi++) begin : g_stage
        logic [PW-1:0] stage_q;
        if (gi == 0) begin : g_head
          always_ff @(posedge clk_25_175) begin
            if (reset) stage_q <= '0;
            else       stage_q <= stage0;
          end
        end else begin : g_next
          always_ff @(posedge clk_25_175) begin
            if (reset) stage_q <= '0;
            else       stage_q <= g_stage[gi-1].stage_q;
          end
        end
      end
      assign tail = g_stage[FETCH_LATENCY-1].stage_q;
    end
  endgenerate

  logic [3*CBITS-1:0] colour_sel;
`ifdef VGA_TESTPATTERN_EN
  assign colour_sel = tail[PW-1] ? tail[3 +: 3*CBITS] : pixstream;
`else
  assign colour_sel = pixstream;
`endif

  logic               h_sync_q, v_sync_q, de_q;
  logic [3*CBITS-1:0] rgb_q;

  always_ff @(posedge clk_25_175) begin
    if (reset) begin
      h_sync_q <= ~HPOL;
      v_sync_q <= ~VPOL;
      de_q     <= 1'b0;
      rgb_q    <= '0;
    end else begin
      h_sync_q <= HPOL ? tail[0] : ~tail[0];
      v_sync_q <= VPOL ? tail[1] : ~tail[1];
      de_q     <= tail[2];
      rgb_q    <= tail[2] ? colour_sel : '0;
    end
  end

  assign h_sync         = h_sync_q;
  assign v_sync         = v_sync_q;
  assign drawing_pixels = de_q;
  assign r              = rgb_q[CBITS-1:0];
  assign g              = rgb_q[CBITS +: CBITS];
  assign b              = rgb_q[2*CBITS +: CBITS];

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA core: generates h/v timing purely from porch parameters.
- Adds programmable sync polarity, power-of-two pixel replication and a latency-matched pixel-fetch pipeline so frame-buffer or pattern sources with N-cycle read latency stay aligned with sync and blanking.
- Sits between the pixel source (pixstream) and the board RGB/sync pins, one pixel clock domain.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_SYNC_POL, 0, 0 = hsync active-low, 1 = active-high
- V_SYNC_POL, 0, same for vsync
- SCALE_LOG2, 0, pixel replication: pix_x/pix_y = counter >> SCALE_LOG2
- FETCH_LATENCY, 1, clocks from pix_x/pix_y to matching pixstream (0..7)
- CBITS, 4, bits per colour channel

Ports:
- clk_25_175  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- pix_x  out  11  fetch column (h_cnt >> SCALE_LOG2)
- pix_y  out  11  fetch row (v_cnt >> SCALE_LOG2)
- fetch_valid  out  1  h_cnt < H_ACTIVE and v_cnt < V_ACTIVE
- line_start  out  1  one-clock pulse when h_cnt == 0
- frame_start  out  1  one-clock pulse when h_cnt == 0 and v_cnt == 0
- frame_count  out  16  completed frames, wraps at 65535->0
- pixstream  in  3*CBITS  {b,g,r}, r in LSBs, valid FETCH_LATENCY clocks after pix_x/pix_y
- h_sync  out  1  registered, polarity per H_SYNC_POL
- v_sync  out  1  registered, polarity per V_SYNC_POL
- drawing_pixels  out  1  registered data-enable
- r, g, b  out  CBITS each  registered colour, zero when drawing_pixels = 0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Internal h_cnt 0..H_TOTAL-1, v_cnt 0..V_TOTAL-1, 11 bits each.
- Each clock h_cnt increments; at H_TOTAL-1 wraps to 0 and v_cnt increments; v_cnt at V_TOTAL-1 with h wrap goes to 0 and frame_count increments.
- Raw hsync active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); raw vsync active for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); bounds inclusive-exclusive, for every line/clock of the range.
- pix_x, pix_y, fetch_valid, line_start, frame_start: combinational from counters (stage 0).
- Raw hsync/vsync/fetch_valid pass through FETCH_LATENCY-deep delay line; final output register samples delayed controls plus pixstream. Outputs therefore reflect counter state FETCH_LATENCY+1 clocks earlier; pixstream for pixel (x,y) appears on r/g/b in the same cycle drawing_pixels asserts for it.
- Polarity applied at output register: inactive level = !active.
- Reset: h_cnt=v_cnt=0, frame_count=0, all delay-line stages cleared to inactive, r/g/b=0, drawing_pixels=0, h_sync/v_sync at inactive level. Reset mid-line restarts at pixel (0,0) next clock; no partial-line residue exits the delay line.
- SCALE_LOG2 only affects pix_x/pix_y; timing unchanged.

Optional Feature:
- VGA_TESTPATTERN_EN defined: extra input port test_pattern (1 bit). When high, stage-0 colour is generated internally instead of pixstream: bar = h_cnt >> (clog2(H_ACTIVE)-3); r = all ones if bar[0], g if bar[1], b if bar[2]; delayed FETCH_LATENCY like pixstream.
- Undefined: no test_pattern port, r/g/b from pixstream only.

Test Plan:
- Defaults, release reset -> first h_sync active (low) 658 clocks after reset deassert (656+1+1), width 96, period 800; v_sync low for exactly 2 lines of every 525; frame_start period 420000.
- Defaults, pixstream = {4'hC,4'hB,4'hA} constant -> r=A,g=B,b=C exactly when drawing_pixels=1, 640 clocks per line, 480 lines; zero elsewhere.
- FETCH_LATENCY=3, pixstream driven as pix_x delayed 3 clocks -> r/g/b equal pix_x[3:0] sequence 0,1,2.. starting on first drawing_pixels cycle.
- SCALE_LOG2=1 -> pix_x holds each value 2 clocks, max 319; pix_y steps every 2 lines, max 239.
- H_SYNC_POL=1,V_SYNC_POL=1 -> syncs idle low, pulse high; assert reset at h_cnt=300,v_cnt=100 -> next frame_start 1 clock after release, outputs inactive during reset, frame_count=0.
- VGA_TESTPATTERN_EN, test_pattern=1 -> 128-pixel bars: black, red, green, yellow, blue (0..4) per line.
